// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core DMEM port and a handshaked memory.
// Stores queue in a circular FIFO and drain in order; loads forward from the youngest matching entry.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [ADDR_W-1:0] core_raddr,
  output logic [DATA_W-1:0] core_rdata,
  output logic              stall,
  output logic              empty,
  output logic              overflow,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic full, push, pop;
  logic [DEPTH-1:0] hit;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign pop   = (state_reg == REQ) && mem_ack;
  // A full buffer can still take a store when the head leaves in the same cycle.
  assign push  = core_we && (!full || pop);

  assign stall     = full;
  assign empty     = (count_reg == '0) && (state_reg == IDLE);
  assign overflow  = overflow_reg;
  assign mem_req   = (state_reg == REQ);
  assign mem_addr  = addr_mem[rd_ptr_reg];
  assign mem_wdata = data_mem[rd_ptr_reg];
  assign mem_raddr = core_raddr;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!push && pop)
      count_next = count_reg - CNT_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = REQ;
      REQ:     if (mem_ack && count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (core_we && !push) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr_reg] <= core_addr;
      data_mem[wr_ptr_reg] <= core_wdata;
    end
  end

  // An entry is live when its distance from the head is below count; the subtraction wraps.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset  = PTR_W'(gi) - rd_ptr_reg;
      assign hit[gi] = ({1'b0, offset} < count_reg) &&
                       (addr_mem[gi][ADDR_W-1:2] == core_raddr[ADDR_W-1:2]);
    end
  endgenerate

  // Walk oldest to youngest so the last hit seen is the youngest store.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = rd_ptr_reg;
    core_rdata = mem_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PTR_W'(k);
      if (hit[idx]) core_rdata = data_mem[idx];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: a per-cycle vector table plus hand-written
// sequences for latency, hold, fill/overflow, wrap-around and mid-transaction reset.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we;
  logic [31:0] core_addr, core_wdata, core_raddr, core_rdata;
  logic        stall, empty, overflow, mem_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_raddr, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_raddr(core_raddr), .core_rdata(core_rdata),
    .stall(stall), .empty(empty), .overflow(overflow),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // Record every accepted memory write, sampled well after the input drive point.
  always @(negedge clk) begin
    #2;
    if (reset && mem_req && mem_ack) begin
      wq.push_back({mem_addr, mem_wdata});
      $display("write addr=%h data=%h", mem_addr, mem_wdata);
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, raddr;
    logic        ack;
    logic [31:0] mrd;
    logic [31:0] e_rdata;
    logic        e_stall, e_empty, e_ovf, e_req;
    logic [31:0] e_maddr, e_mwdata;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, wdata, raddr,
                              input logic ack, input logic [31:0] mrd, rd,
                              input logic st, em, ov, rq, input logic [31:0] ma, mw);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.raddr = raddr; v.ack = ack; v.mrd = mrd;
    v.e_rdata = rd; v.e_stall = st; v.e_empty = em; v.e_ovf = ov; v.e_req = rq;
    v.e_maddr = ma; v.e_mwdata = mw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; core_we = 1'b0; mem_ack = 1'b0;
    core_addr = '0; core_wdata = '0; core_raddr = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d);
    core_we = 1'b1; core_addr = a; core_wdata = d;
    @(negedge clk);
    core_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] last_addr, last_data;
    logic        have_last;
    int          n, cyc;

    // Columns: we addr wdata raddr ack mem_rdata | rdata stall empty ovf req mem_addr mem_wdata
    vecs[0]  = mk(1, 32'h200, 32'h11, 32'h200, 0, 32'h99, 32'h99, 0, 1, 0, 0, 32'h0,   32'h0);
    vecs[1]  = mk(1, 32'h200, 32'h22, 32'h202, 0, 32'h99, 32'h11, 0, 0, 0, 0, 32'h200, 32'h11);
    vecs[2]  = mk(0, 32'h0,   32'h0,  32'h202, 0, 32'h99, 32'h22, 0, 0, 0, 1, 32'h200, 32'h11);
    vecs[3]  = mk(0, 32'h0,   32'h0,  32'h204, 0, 32'h55, 32'h55, 0, 0, 0, 1, 32'h200, 32'h11);
    vecs[4]  = mk(1, 32'h8,   32'h33, 32'h200, 1, 32'h99, 32'h22, 0, 0, 0, 1, 32'h200, 32'h11);
    vecs[5]  = mk(1, 32'hC,   32'h44, 32'h8,   0, 32'h99, 32'h33, 0, 0, 0, 1, 32'h200, 32'h22);
    vecs[6]  = mk(1, 32'h10,  32'h55, 32'hC,   0, 32'h99, 32'h44, 0, 0, 0, 1, 32'h200, 32'h22);
    vecs[7]  = mk(1, 32'h14,  32'h66, 32'h10,  0, 32'h99, 32'h55, 1, 0, 0, 1, 32'h200, 32'h22);
    vecs[8]  = mk(1, 32'h18,  32'h77, 32'h14,  1, 32'h99, 32'h99, 1, 0, 1, 1, 32'h200, 32'h22);
    vecs[9]  = mk(0, 32'h0,   32'h0,  32'h18,  1, 32'h99, 32'h77, 1, 0, 1, 1, 32'h8,   32'h33);
    vecs[10] = mk(0, 32'h0,   32'h0,  32'h8,   1, 32'hAB, 32'hAB, 0, 0, 1, 1, 32'hC,   32'h44);
    vecs[11] = mk(0, 32'h0,   32'h0,  32'h10,  1, 32'hAB, 32'h55, 0, 0, 1, 1, 32'h10,  32'h55);
    vecs[12] = mk(0, 32'h0,   32'h0,  32'h10,  1, 32'hAB, 32'hAB, 0, 0, 1, 1, 32'h18,  32'h77);
    vecs[13] = mk(0, 32'h0,   32'h0,  32'h18,  0, 32'hAB, 32'hAB, 0, 1, 1, 0, 32'h8,   32'h33);

    reset = 1'b0; core_we = 1'b0; mem_ack = 1'b0;
    core_addr = '0; core_wdata = '0; core_raddr = '0; mem_rdata = '0;
    do_reset();
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);

    // Table: forwarding, fill, drop, push+pop at full and wrap-around validity.
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      core_we = vecs[i].we; core_addr = vecs[i].addr; core_wdata = vecs[i].wdata;
      core_raddr = vecs[i].raddr; mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrd;
      #1;
      $display("vec %0d raddr=%h rdata=%h req=%b maddr=%h", i, core_raddr, core_rdata, mem_req, mem_addr);
      chk($sformatf("v%0d_rdata", i), core_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_empty", i), {31'b0, empty}, {31'b0, vecs[i].e_empty});
      chk($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].e_ovf});
      chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_mwdata);
      chk($sformatf("v%0d_mraddr", i), mem_raddr, vecs[i].raddr);
      @(negedge clk);
    end

    // Single store, ack tied high: request two cycles after the push.
    do_reset(); wq.delete();
    mem_ack = 1'b1;
    push_one(32'h100, 32'hDEADBEEF);
    #1;
    chk("single_req_e1", {31'b0, mem_req}, 32'd0);
    chk("single_empty_e1", {31'b0, empty}, 32'd0);
    @(negedge clk); #1;
    chk("single_req_e2", {31'b0, mem_req}, 32'd1);
    chk("single_maddr", mem_addr, 32'h100);
    chk("single_mwdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("single_empty_after", {31'b0, empty}, 32'd1);
    chk("single_nwrites", wq.size(), 32'd1);
    if (wq.size() == 1) chk("single_write", wq[0][63:32], 32'h100);

    // Hold stability while the memory withholds ack.
    do_reset(); wq.delete();
    push_one(32'h40, 32'h12345678);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold%0d_req", c), {31'b0, mem_req}, 32'd1);
      chk($sformatf("hold%0d_maddr", c), mem_addr, 32'h40);
      chk($sformatf("hold%0d_mwdata", c), mem_wdata, 32'h12345678);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    @(negedge clk); #1;
    chk("hold_empty", {31'b0, empty}, 32'd1);
    chk("hold_nwrites", wq.size(), 32'd1);

    // Fill to full, drop a fifth store, then drain in order.
    do_reset(); wq.delete();
    for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'hA0 + 32'(i));
    #1;
    chk("fill_stall", {31'b0, stall}, 32'd1);
    chk("fill_ovf_before", {31'b0, overflow}, 32'd0);
    push_one(32'h10, 32'hEE);
    #1;
    chk("fill_ovf", {31'b0, overflow}, 32'd1);
    chk("fill_stall_after_drop", {31'b0, stall}, 32'd1);
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("fill_empty", {31'b0, empty}, 32'd1);
    chk("fill_nwrites", wq.size(), 32'd4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk($sformatf("fill_w%0d_addr", i), wq[i][63:32], 32'(4 * i));
      chk($sformatf("fill_w%0d_data", i), wq[i][31:0], 32'hA0 + 32'(i));
    end

    // Ten stores with ack toggling; forwarding of the youngest store across wrap.
    do_reset(); wq.delete();
    n = 0; cyc = 0; have_last = 1'b0; last_addr = '0; last_data = '0;
    while (n < 10 && cyc < 200) begin
      mem_ack = (cyc % 2 == 0);
      core_raddr = last_addr; mem_rdata = 32'hBAD0BAD0;
      if (stall && !mem_ack) core_we = 1'b0;
      else begin
        core_we = 1'b1; core_addr = 32'h300 + 32'(4 * n); core_wdata = 32'h1000 + 32'(n);
      end
      #1;
      if (have_last) chk($sformatf("wrap_fwd_c%0d", cyc), core_rdata, last_data);
      if (core_we) begin
        last_addr = core_addr; last_data = core_wdata; have_last = 1'b1; n++;
      end
      @(negedge clk);
      cyc++;
    end
    core_we = 1'b0;
    chk("wrap_all_pushed", n, 32'd10);
    mem_ack = 1'b1;
    cyc = 0;
    while (!empty && cyc < 20) begin @(negedge clk); cyc++; end
    #1;
    chk("wrap_empty", {31'b0, empty}, 32'd1);
    chk("wrap_ovf", {31'b0, overflow}, 32'd0);
    chk("wrap_nwrites", wq.size(), 32'd10);
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      chk($sformatf("wrap_w%0d_addr", i), wq[i][63:32], 32'h300 + 32'(4 * i));
      chk($sformatf("wrap_w%0d_data", i), wq[i][31:0], 32'h1000 + 32'(i));
    end

    // Reset between edges while a write is being requested.
    do_reset(); wq.delete();
    for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4 * i), 32'h77 + 32'(i));
    #1;
    chk("mid_req_before", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_req_after", {31'b0, mem_req}, 32'd0);
    chk("mid_empty", {31'b0, empty}, 32'd1);
    chk("mid_ovf", {31'b0, overflow}, 32'd0);
    chk("mid_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1; wq.delete();
    repeat (6) @(negedge clk);
    #1;
    chk("mid_nwrites", wq.size(), 32'd0);
    chk("mid_req_idle", {31'b0, mem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
